// File: rtl/stream_arb_mux_if.sv
`default_nettype none
// ============================================================================
// Module  : stream_arb_mux_if
// Brief   : Bundle of N source channels and one sink for stream_arb_mux.
//           The slave modport is the multiplexer's view; master is the
//           producer/consumer environment.
// Revision: 1.0 - initial release
// ============================================================================
interface stream_arb_mux_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_last;
  logic [WIDTH*CHANNELS-1:0] in_data;
  logic [CHANNELS-1:0]       in_ready;
  logic                      out_valid;
  logic                      out_last;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_ready;

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_last, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_last, out_data, out_sel
  );
endinterface
`default_nettype wire

// File: rtl/stream_arb_mux.sv
`default_nettype none
// ============================================================================
// Module  : stream_arb_mux
// Brief   : N-to-1 valid/ready stream multiplexer with round-robin or fixed
//           priority arbitration, packet lock and a registered output stage.
// Revision: 1.0 - initial release
// ============================================================================
module stream_arb_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_arb_mux_if.slave  bus
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Packet lock state: OPEN lets the arbiter choose, LOCKED pins the grant.
  localparam logic [0:0] ST_OPEN   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]          r_state;
  logic [0:0]          w_state_nxt;
  logic [SEL_W-1:0]    r_lock_ch;
  logic [SEL_W-1:0]    w_lock_ch_nxt;
  logic [SEL_W-1:0]    r_rr_ptr;
  logic [SEL_W-1:0]    w_arb_ch;
  logic                w_arb_hit;
  int                  w_idx;
  logic [SEL_W-1:0]    w_grant;
  logic                w_slot_free;
  logic                w_accept;
  logic [CHANNELS-1:0] w_ready;
  logic                w_sel_last;
  logic [WIDTH-1:0]    w_sel_data;

  logic                r_out_valid;
  logic                r_out_last;
  logic [WIDTH-1:0]    r_out_data;
  logic [SEL_W-1:0]    r_out_sel;

  // The output register can take a beat when empty or being drained.
  assign w_slot_free = ~r_out_valid | bus.out_ready;

  // Arbiter: first valid channel scanning upward (with wrap) from the start point.
  always_comb begin
    w_arb_ch  = '0;
    w_arb_hit = 1'b0;
    w_idx     = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_idx = ((MODE == 0) ? int'(r_rr_ptr) : 0) + k;
      if (w_idx >= CHANNELS) w_idx = w_idx - CHANNELS;
      if (!w_arb_hit && bus.in_valid[w_idx]) begin
        w_arb_hit = 1'b1;
        w_arb_ch  = SEL_W'(w_idx);
      end
    end
  end

  // Lock state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_OPEN;
      r_lock_ch <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_ch <= w_lock_ch_nxt;
    end
  end

  // Lock next state: a non-last beat pins the channel, a last beat releases it.
  always_comb begin
    w_state_nxt   = r_state;
    w_lock_ch_nxt = r_lock_ch;
    if (w_accept) begin
      if (w_sel_last) begin
        w_state_nxt = ST_OPEN;
      end else begin
        w_state_nxt   = ST_LOCKED;
        w_lock_ch_nxt = w_grant;
      end
    end
  end

  // Grant decode: while locked only the lock owner may be served, even if idle.
  always_comb begin
    w_grant    = (r_state == ST_LOCKED) ? r_lock_ch : w_arb_ch;
    w_ready    = '0;
    w_sel_last = 1'b0;
    w_sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_grant == SEL_W'(i)) begin
        w_ready[i] = w_slot_free & bus.in_valid[i] & rst_n;
        w_sel_last = bus.in_last[i];
        w_sel_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
    w_accept = |w_ready;
  end

  // Output register and round-robin pointer; pointer moves only at packet end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_rr_ptr    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_sel_last;
      r_out_data  <= w_sel_data;
      r_out_sel   <= w_grant;
      if (MODE == 0 && w_sel_last) begin
        r_rr_ptr <= (w_grant == SEL_W'(CHANNELS - 1)) ? '0 : w_grant + SEL_W'(1);
      end
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;
endmodule
`default_nettype wire

// File: tb/tb_stream_arb_mux.sv
`default_nettype none
// ============================================================================
// Module  : tb_stream_arb_mux
// Brief   : Self-checking bench; a round-robin and a fixed-priority instance
//           are driven with random packets and compared to a reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_stream_arb_mux;
  localparam int W = 32;
  localparam int N = 4;
  localparam int PH_FULL  = 0;
  localparam int PH_STALL = 1;
  localparam int PH_RAND  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_arb_mux_if #(.WIDTH(W), .CHANNELS(N)) bus0 ();
  stream_arb_mux_if #(.WIDTH(W), .CHANNELS(N)) bus1 ();

  stream_arb_mux #(.WIDTH(W), .CHANNELS(N), .MODE(0)) u_rr (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  stream_arb_mux #(.WIDTH(W), .CHANNELS(N), .MODE(1)) u_fp (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  // Stimulus: index 0 drives the round-robin instance, 1 the fixed-priority one.
  logic [N-1:0] s_valid [2];
  logic [N-1:0] s_last  [2];
  logic [W-1:0] s_data  [2][N];
  logic         s_ordy  [2];

  assign bus0.in_valid  = s_valid[0];
  assign bus0.in_last   = s_last[0];
  assign bus0.out_ready = s_ordy[0];
  assign bus1.in_valid  = s_valid[1];
  assign bus1.in_last   = s_last[1];
  assign bus1.out_ready = s_ordy[1];

  for (genvar c = 0; c < N; c++) begin : g_pack
    assign bus0.in_data[c*W +: W] = s_data[0][c];
    assign bus1.in_data[c*W +: W] = s_data[1][c];
  end

  // Reference model: held beat, lock owner and round-robin start point.
  bit           m_valid   [2];
  bit           m_last    [2];
  logic [W-1:0] m_data    [2];
  int           m_sel     [2];
  int           m_ptr     [2];
  bit           m_locked  [2];
  int           m_lock_ch [2];
  int           m_gnt     [2];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Channel the sink would take this cycle, or -1 when nobody is served.
  function automatic int ref_grant(input int d);
    int c;
    if (!rst_n) return -1;
    if (m_valid[d] && !s_ordy[d]) return -1;
    if (m_locked[d]) return s_valid[d][m_lock_ch[d]] ? m_lock_ch[d] : -1;
    for (int k = 0; k < N; k++) begin
      c = (((d == 0) ? m_ptr[d] : 0) + k) % N;
      if (s_valid[d][c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0; m_last[d] = 0; m_data[d] = '0; m_sel[d] = 0;
      m_ptr[d] = 0; m_locked[d] = 0; m_lock_ch[d] = 0; m_gnt[d] = -1;
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d.out_valid", d), (d == 0) ? bus0.out_valid : bus1.out_valid, m_valid[d]);
      if (m_valid[d]) begin
        check_eq($sformatf("d%0d.out_last", d), (d == 0) ? bus0.out_last : bus1.out_last, m_last[d]);
        check_eq($sformatf("d%0d.out_data", d), (d == 0) ? bus0.out_data : bus1.out_data, m_data[d]);
        check_eq($sformatf("d%0d.out_sel", d), (d == 0) ? bus0.out_sel : bus1.out_sel, m_sel[d]);
      end
    end
  endtask

  // One clock: check in_ready before the edge, advance model, check outputs after.
  task automatic cycle();
    int g;
    #1;
    for (int d = 0; d < 2; d++) begin
      m_gnt[d] = ref_grant(d);
      check_eq($sformatf("d%0d.in_ready", d), (d == 0) ? bus0.in_ready : bus1.in_ready,
               (m_gnt[d] >= 0) ? (64'd1 << m_gnt[d]) : 64'd0);
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int d = 0; d < 2; d++) begin
        g = m_gnt[d];
        if (g >= 0) begin
          m_valid[d] = 1; m_data[d] = s_data[d][g]; m_last[d] = s_last[d][g]; m_sel[d] = g;
          if (s_last[d][g]) begin
            m_locked[d] = 0;
            if (d == 0) m_ptr[d] = (g + 1) % N;
          end else begin
            m_locked[d] = 1; m_lock_ch[d] = g;
          end
        end else if (s_ordy[d]) begin
          m_valid[d] = 0;
        end
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Retire accepted beats and present new ones; pending beats are held unchanged.
  task automatic refresh(input int ph);
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < N; c++) begin
        if (m_gnt[d] == c) s_valid[d][c] = 1'b0;
        if (!s_valid[d][c]) begin
          if (ph == PH_FULL) begin
            s_valid[d][c] = 1'b1; s_last[d][c] = 1'b1; s_data[d][c] = 32'hDEADBEEF;
          end else if ($urandom_range(0, 1) == 1) begin
            s_valid[d][c] = 1'b1;
            s_last[d][c]  = ($urandom_range(0, 2) != 0);
            s_data[d][c]  = $urandom;
          end
        end
      end
      s_ordy[d] = (ph == PH_FULL) ? 1'b1 : (ph == PH_STALL) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  endtask

  // Main sequence: reset with all sources valid, full-rate rotation, stall, random, mid-packet reset.
  initial begin
    model_reset();
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = '1; s_last[d] = '1; s_ordy[d] = 1'b1;
      for (int c = 0; c < N; c++) s_data[d][c] = 32'hDEADBEEF;
    end
    @(negedge clk);
    repeat (2) cycle();
    check_eq("rst.out_data", bus0.out_data, 64'd0);
    check_eq("rst.out_sel", bus0.out_sel, 64'd0);
    check_eq("rst.out_last", bus0.out_last, 64'd0);
    rst_n = 1'b1;

    cycle();
    check_eq("first.out_sel_rr", bus0.out_sel, 64'd0);
    check_eq("first.out_sel_fp", bus1.out_sel, 64'd0);
    for (int i = 0; i < 6; i++) begin
      refresh(PH_FULL);
      cycle();
    end

    for (int i = 0; i < 5; i++) begin
      refresh(PH_STALL);
      cycle();
      check_eq("stall.out_data", bus0.out_data, 64'hDEADBEEF);
    end

    for (int i = 0; i < 1500; i++) begin
      refresh(PH_RAND);
      cycle();
    end

    for (int t = 0; t < 300 && !m_locked[0]; t++) begin
      refresh(PH_RAND);
      cycle();
    end
    check_eq("lock_wait", m_locked[0], 64'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    cycle();
    rst_n = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      refresh(PH_RAND);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
